// File: rtl/uart_rx_param_if.sv
// UART receive port bundle: serial line in, payload out with valid/ready handshake.
// No logic of its own; width of the payload follows DATA_BITS.
// master = receiver side (drives payload), slave = consumer side (drives rxd and ready).
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic                 rxd;
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 data_ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;
  logic [31:0]          frame_count;

  modport master (
    input  rxd,
    input  data_ready,
    output data_out,
    output data_valid,
    output parity_err,
    output frame_err,
    output overrun,
    output frame_count
  );

  modport slave (
    output rxd,
    output data_ready,
    input  data_out,
    input  data_valid,
    input  parity_err,
    input  frame_err,
    input  overrun,
    input  frame_count
  );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: sync'd rxd, start glitch reject, parity/framing check.
// Latency: data_valid rises ~2 + CLKS_PER_BIT/2 + (DATA_BITS+P+1)*CLKS_PER_BIT after start edge.
// Backpressure: one-deep output held until data_ready; a frame finishing while held is dropped with overrun.
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int CNT_W        = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  uart_rx_param_if.master       if_rx
);

  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] C_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] C_IDX_ONE  = IDX_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // synchroniser and FSM state
  logic                 r_sync1;
  logic                 r_sync2;
  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_pbit;
  logic                 r_need_high;

  // output holding registers
  logic [DATA_BITS-1:0] r_data_out;
  logic                 r_valid;
  logic                 r_perr;
  logic                 r_ferr;
  logic                 r_overrun;
  logic [31:0]          r_count;

  // next-state and per-frame results
  logic                 w_rxs;
  logic                 w_sample;
  state_t               w_state_nxt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [IDX_W-1:0]     w_idx_nxt;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic                 w_pbit_nxt;
  logic                 w_need_high_nxt;
  logic                 w_done;
  logic                 w_ferr_new;
  logic                 w_perr_new;
  logic                 w_load;

  assign w_rxs    = r_sync2;
  assign w_sample = (r_cnt == C_LAST);

  // Parity is checked against the assembled payload; the mode is fixed at elaboration.
  assign w_perr_new = (PARITY_MODE == 1) ? ((^r_shift) ^ r_pbit) :
                      (PARITY_MODE == 2) ? ~((^r_shift) ^ r_pbit) :
                      1'b0;

  // A completed frame is accepted unless the previous one is still held and not being taken now.
  assign w_load = w_done && (!r_valid || if_rx.data_ready);

  // Two-flop synchroniser on the asynchronous serial line; idles high like the line itself.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= if_rx.rxd;
      r_sync2 <= r_sync1;
    end
  end

  // FSM state, bit-period counter, bit index and shift register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
      r_pbit      <= 1'b0;
      r_need_high <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_idx       <= w_idx_nxt;
      r_shift     <= w_shift_nxt;
      r_pbit      <= w_pbit_nxt;
      r_need_high <= w_need_high_nxt;
    end
  end

  // Frame sequencing: start-bit qualification at half a bit, then one sample per bit period.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_idx_nxt       = r_idx;
    w_shift_nxt     = r_shift;
    w_pbit_nxt      = r_pbit;
    w_need_high_nxt = r_need_high;
    w_done          = 1'b0;
    w_ferr_new      = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        // After a framing error the line must be seen high once, so a held break
        // produces a single frame rather than a stream of zero frames.
        if (r_need_high) begin
          if (w_rxs) begin
            w_need_high_nxt = 1'b0;
          end
        end else if (!w_rxs) begin
          w_state_nxt = S_START;
        end
      end

      S_START: begin
        if (r_cnt == C_HALF) begin
          w_cnt_nxt = '0;
          if (!w_rxs) begin
            // Still low mid-start-bit: real start; counter now aligned to bit centres.
            w_idx_nxt   = '0;
            w_state_nxt = S_DATA;
          end else begin
            // Short low pulse: treat as noise.
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + C_ONE;
        end
      end

      S_DATA: begin
        if (w_sample) begin
          w_cnt_nxt   = '0;
          // LSB arrives first, so shifting in at the top leaves it at bit 0 after the last bit.
          w_shift_nxt = {w_rxs, r_shift[DATA_BITS-1:1]};
          w_idx_nxt   = r_idx + C_IDX_ONE;
          if (r_idx == C_IDX_LAST) begin
            w_idx_nxt   = '0;
            w_state_nxt = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
          end
        end else begin
          w_cnt_nxt = r_cnt + C_ONE;
        end
      end

      S_PARITY: begin
        if (w_sample) begin
          w_cnt_nxt   = '0;
          w_pbit_nxt  = w_rxs;
          w_state_nxt = S_STOP;
        end else begin
          w_cnt_nxt = r_cnt + C_ONE;
        end
      end

      S_STOP: begin
        if (w_sample) begin
          // Completing mid-stop-bit lets the next start edge be caught on back-to-back frames.
          w_cnt_nxt       = '0;
          w_done          = 1'b1;
          w_ferr_new      = ~w_rxs;
          w_need_high_nxt = ~w_rxs;
          w_state_nxt     = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + C_ONE;
        end
      end

      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output register: load, hold, release on transfer, or flag overrun on a dropped frame.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_data_out <= '0;
      r_valid    <= 1'b0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_overrun  <= 1'b0;
      r_count    <= '0;
    end else begin
      r_overrun <= 1'b0;
      if (w_done) begin
        r_count <= r_count + 32'd1;
      end
      if (w_load) begin
        r_data_out <= r_shift;
        r_perr     <= w_perr_new;
        r_ferr     <= w_ferr_new;
        r_valid    <= 1'b1;
      end else if (w_done) begin
        // Previous frame still unclaimed: keep it and report the loss.
        r_overrun <= 1'b1;
      end else if (r_valid && if_rx.data_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign if_rx.data_out    = r_data_out;
  assign if_rx.data_valid  = r_valid;
  assign if_rx.parity_err  = r_perr;
  assign if_rx.frame_err   = r_ferr;
  assign if_rx.overrun     = r_overrun;
  assign if_rx.frame_count = r_count;

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver, the next generation of the fixed 8N1 receive FSM. Adds configurable data width, baud divisor and parity, plus:
- 2-flop input synchroniser
- start-bit glitch rejection
- parity and framing error detection
- valid/ready output handshake with overrun detection

Sits between the board RX pin and a byte consumer (FIFO or command decoder) in the same clock domain.

Parameters:
CLKS_PER_BIT, 434, clk cycles per bit period (50 MHz / 115200); legal range >= 4.
DATA_BITS, 8, payload bits per frame, LSB first; legal range 5..9.
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd.
CNT_W, 16, width of the bit-period counter; must hold CLKS_PER_BIT-1.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
rxd  in  1  serial line, asynchronous to clk, idle high.
data_out  out  DATA_BITS  received payload, held stable while data_valid=1.
data_valid  out  1  payload available; held until accepted.
data_ready  in  1  consumer accepts; a transfer occurs on a clk edge where data_valid & data_ready.
parity_err  out  1  parity mismatch on the frame in data_out; valid with data_valid; 0 when PARITY_MODE=0.
frame_err  out  1  stop bit sampled 0 on the frame in data_out; valid with data_valid.
overrun  out  1  one-cycle pulse: a frame completed while data_valid=1 and no transfer in that cycle.
frame_count  out  32  count of completed frames (including errored and overrun frames); wraps at 2^32.

Behaviour:
- Reset (async assert, sync deassert in the system):
  - state=IDLE; counter and bit index = 0.
  - data_out=0, data_valid=0, parity_err=0, frame_err=0, overrun=0, frame_count=0.
  - Both synchroniser flops = 1.
- rxd passes through 2 flops (rxs); all FSM decisions use rxs only.
- Counter counts 0..CLKS_PER_BIT-1. A "sample point" is counter==CLKS_PER_BIT-1; the counter then returns to 0.
- IDLE: counter held at 0. On rxs==0, go to START with counter=0.
- START: at counter==CLKS_PER_BIT/2-1 (integer divide):
  - rxs==0: counter=0, bit index=0, go to DATA (sampling now centred in each bit).
  - rxs==1: glitch; return to IDLE with no output change.
- DATA: at each sample point, shift rxs into bit[index] and increment index. After bit DATA_BITS-1 is sampled, go to PARITY if PARITY_MODE!=0, else STOP.
- PARITY: at the sample point, capture the parity bit and go to STOP.
  - Even: error if XOR(data, pbit)=1.
  - Odd: error if XOR(data, pbit)=0.
- STOP: at the sample point, set frame_err_next = ~rxs, complete the frame and return to IDLE in the same edge. A new start bit may be detected from the next cycle (mid-stop-bit re-arm, so back-to-back frames are supported).
- Frame completion is one edge:
  - frame_count increments.
  - If data_valid==0, or data_ready==1 in this cycle: load data_out/parity_err/frame_err and set data_valid=1.
  - Otherwise: drop the new frame, keep the old data, and pulse overrun=1 for exactly one cycle.
- Handshake:
  - data_valid falls on the edge where data_valid & data_ready, unless a completion loads new data on the same edge (then it stays 1 with the new data).
  - data_ready while data_valid=0 has no effect.
  - data_out, parity_err and frame_err do not change while data_valid=1 without a transfer.
- Latency: data_valid rises on the edge after the STOP sample point, approx. 2 + CLKS_PER_BIT/2 + (DATA_BITS + P + 1)·CLKS_PER_BIT cycles after the rxd falling edge (P=1 if parity enabled).
- A break (rxd held low) yields a frame with data=0 and frame_err=1. The FSM then re-enters START only after rxs returns high and falls again: IDLE requires one observed rxs==1 before re-arming after a frame_err.
- Reset mid-frame aborts the frame: no data_valid and no frame_count increment.

Test Plan:
- CLKS_PER_BIT=16, 8N1, send 0xA5 with data_ready=1 -> data_valid pulses 1 cycle, data_out=0xA5, frame_err=0, parity_err=0, frame_count=1.
- Even parity: send 0x03 with pbit=0, then 0x03 with pbit=1 -> parity_err=0 then parity_err=1; both frames delivered, frame_count=2.
- data_ready=0, send 0x11 then 0x22 back-to-back (1 stop bit) -> data_out stays 0x11, overrun pulses once, frame_count=2; raising data_ready clears data_valid.
- rxd low pulse of 5 cycles (< CLKS_PER_BIT/2) while idle -> no data_valid, state back to IDLE, frame_count unchanged; a following 0x5A frame is received correctly.
- Stop bit forced 0 on 0xFF, then rxd held low for 3 frame times -> one frame data_out=0xFF, frame_err=1, and no further frames until rxd returns high.
- Assert reset at bit 4 of a frame, release, send 0x3C -> outputs are reset values during reset; only 0x3C is delivered, frame_count=1. Repeat with DATA_BITS=7 and odd parity for 0x3C.
